// File: rtl/ad_lvds_serializer.sv
// Serial output stage: 2-entry sample buffer feeding LANE_NUM MSB-first lanes,
// with frame clock, word-start strobe and a training pattern when idle.
module ad_lvds_serializer #(
   parameter int                    DATA_WIDTH    = 14,
   parameter int                    LANE_NUM      = 2,
   parameter int                    SER_RATIO     = DATA_WIDTH / LANE_NUM,
   parameter logic [DATA_WIDTH-1:0] TRAIN_PATTERN = 14'h1A5A,
   parameter int                    TRAIN_WORDS   = 4
) (
   input  logic                  clk_ser,
   input  logic                  reset_ser,
   input  logic                  i_data_valid,
   input  logic [DATA_WIDTH-1:0] iv_data,
   output logic                  o_data_ready,
   output logic [LANE_NUM-1:0]   ov_lane,
   output logic                  o_fco,
   output logic                  o_word_start
);

   localparam int CNT_W = (SER_RATIO > 1) ? $clog2(SER_RATIO) : 1;
   localparam int TRN_W = $clog2(TRAIN_WORDS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SER_RATIO - 1);
   localparam logic [CNT_W-1:0] CNT_FCO  = CNT_W'((SER_RATIO + 1) / 2);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [TRN_W-1:0] TRN_DONE = TRN_W'(TRAIN_WORDS);
   localparam logic [TRN_W-1:0] TRN_ONE  = TRN_W'(1);
   localparam logic [0:0]       ST_WAIT  = 1'b0;
   localparam logic [0:0]       ST_RUN   = 1'b1;

   logic [CNT_W-1:0]      bit_cnt_r;
   logic                  primed_r;
   logic [0:0]            state_r;
   logic [TRN_W-1:0]      train_cnt_r;
   logic [DATA_WIDTH-1:0] mem_r [0:1];
   logic                  wr_ptr_r;
   logic                  rd_ptr_r;
   logic [1:0]            count_r;
   logic [DATA_WIDTH-1:0] shift_r;

   logic                  boundary_s;
   logic                  push_s;
   logic                  pop_s;
   logic [DATA_WIDTH-1:0] load_word_s;
   logic [DATA_WIDTH-1:0] shift_nxt_s;
   logic [CNT_W-1:0]      cnt_nxt_s;
   logic [LANE_NUM-1:0]   lane_nxt_s;
   logic [0:0]            state_nxt_s;
   logic [TRN_W-1:0]      train_nxt_s;

   assign o_data_ready = (state_r == ST_RUN) && (count_r != 2'd2);

   // The first cycle after reset release behaves as a word boundary.
   always_comb begin
      boundary_s = (bit_cnt_r == CNT_LAST) || !primed_r;
      push_s     = i_data_valid && o_data_ready;
      pop_s      = boundary_s && (state_r == ST_RUN) && (count_r != 2'd0);
   end

   // Next shift content: load at a boundary, else shift each lane slice left.
   always_comb begin
      shift_nxt_s = shift_r;
      cnt_nxt_s   = bit_cnt_r;
      lane_nxt_s  = {LANE_NUM{1'b0}};
      load_word_s = TRAIN_PATTERN;
      if (boundary_s) begin
         if (pop_s) begin
            load_word_s = mem_r[rd_ptr_r];
         end else begin
            load_word_s = TRAIN_PATTERN;
         end
         shift_nxt_s = load_word_s;
         cnt_nxt_s   = CNT_ZERO;
      end else begin
         for (int k = 0; k < LANE_NUM; k++) begin
            shift_nxt_s[k*SER_RATIO +: SER_RATIO] = {shift_r[k*SER_RATIO +: SER_RATIO-1], 1'b0};
         end
         cnt_nxt_s = bit_cnt_r + CNT_ONE;
      end
      for (int k = 0; k < LANE_NUM; k++) begin
         lane_nxt_s[k] = shift_nxt_s[k*SER_RATIO + SER_RATIO - 1];
      end
   end

   // Training sequencer: count loaded words in WAIT, then enter RUN for good.
   always_comb begin
      state_nxt_s = state_r;
      train_nxt_s = train_cnt_r;
      if (boundary_s) begin
         case (state_r)
            ST_WAIT: begin
               if (train_cnt_r == TRN_DONE) begin
                  state_nxt_s = ST_RUN;
               end else begin
                  train_nxt_s = train_cnt_r + TRN_ONE;
               end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = ST_WAIT;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Framing counters, state and shift register.
   always_ff @(posedge clk_ser or posedge reset_ser) begin
      if (reset_ser) begin
         bit_cnt_r   <= CNT_ZERO;
         primed_r    <= 1'b0;
         state_r     <= ST_WAIT;
         train_cnt_r <= {TRN_W{1'b0}};
         shift_r     <= {DATA_WIDTH{1'b0}};
      end else begin
         bit_cnt_r   <= cnt_nxt_s;
         primed_r    <= 1'b1;
         state_r     <= state_nxt_s;
         train_cnt_r <= train_nxt_s;
         shift_r     <= shift_nxt_s;
      end
   end

   // Two-entry FIFO; a same-cycle push and pop keep the count.
   always_ff @(posedge clk_ser or posedge reset_ser) begin
      if (reset_ser) begin
         mem_r[0] <= {DATA_WIDTH{1'b0}};
         mem_r[1] <= {DATA_WIDTH{1'b0}};
         wr_ptr_r <= 1'b0;
         rd_ptr_r <= 1'b0;
         count_r  <= 2'd0;
      end else begin
         if (push_s) begin
            mem_r[wr_ptr_r] <= iv_data;
            wr_ptr_r        <= ~wr_ptr_r;
         end
         if (pop_s) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + 2'd1;
            2'b01:   count_r <= count_r - 2'd1;
            default: count_r <= count_r;
         endcase
      end
   end

   // Registered serial outputs, aligned with the bit counter they reflect.
   always_ff @(posedge clk_ser or posedge reset_ser) begin
      if (reset_ser) begin
         ov_lane      <= {LANE_NUM{1'b0}};
         o_fco        <= 1'b0;
         o_word_start <= 1'b0;
      end else begin
         ov_lane      <= lane_nxt_s;
         o_fco        <= (cnt_nxt_s < CNT_FCO);
         o_word_start <= (cnt_nxt_s == CNT_ZERO);
      end
   end

endmodule

// File: tb/tb_ad_lvds_serializer.sv
// Randomized bench for ad_lvds_serializer: a queue-based word-level model
// predicts every output cycle by cycle, plus directed framing checks.
module tb_ad_lvds_serializer;

   localparam int          DW = 14;
   localparam int          LN = 2;
   localparam int          SR = 7;
   localparam int          TW = 4;
   localparam logic [13:0] TP = 14'h1A5A;

   logic          clk_ser = 1'b0;
   logic          reset_ser = 1'b0;
   logic          i_data_valid = 1'b0;
   logic [DW-1:0] iv_data = '0;
   logic          o_data_ready;
   logic [LN-1:0] ov_lane;
   logic          o_fco;
   logic          o_word_start;

   int checks = 0;
   int errors = 0;

   // reference model state (word level)
   bit            m_shown;
   bit            m_run;
   int            m_cnt;
   int            m_train;
   logic [DW-1:0] m_word;
   logic [DW-1:0] m_q[$];

   ad_lvds_serializer #(
      .DATA_WIDTH(DW), .LANE_NUM(LN), .SER_RATIO(SR),
      .TRAIN_PATTERN(TP), .TRAIN_WORDS(TW)
   ) dut (
      .clk_ser(clk_ser), .reset_ser(reset_ser),
      .i_data_valid(i_data_valid), .iv_data(iv_data),
      .o_data_ready(o_data_ready), .ov_lane(ov_lane),
      .o_fco(o_fco), .o_word_start(o_word_start)
   );

   always #5 clk_ser = ~clk_ser;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic model_reset();
      m_shown = 1'b0; m_run = 1'b0; m_cnt = 0; m_train = 0; m_word = '0;
      m_q.delete();
   endtask

   function automatic bit model_ready();
      return m_run && (m_q.size() < 2);
   endfunction

   task automatic check_outputs();
      logic [LN-1:0] el;
      el = '0;
      for (int k = 0; k < LN; k++) el[k] = m_shown ? m_word[k*SR + SR - 1 - m_cnt] : 1'b0;
      chk("lane", 16'(ov_lane), 16'(el));
      chk("fco", 16'(o_fco), 16'(m_shown && (m_cnt < (SR + 1) / 2)));
      chk("word_start", 16'(o_word_start), 16'(m_shown && (m_cnt == 0)));
      chk("ready", 16'(o_data_ready), 16'(model_ready()));
   endtask

   task automatic model_step(input bit v, input logic [DW-1:0] d);
      bit acc;
      bit boundary;
      acc      = v && model_ready();
      boundary = !m_shown || (m_cnt == SR - 1);
      if (boundary) begin
         if (m_run && m_q.size() > 0) m_word = m_q.pop_front();
         else m_word = TP;
         if (!m_run) begin
            if (m_train == TW) m_run = 1'b1;
            else m_train++;
         end
         m_cnt = 0;
         m_shown = 1'b1;
      end else begin
         m_cnt++;
      end
      if (acc) m_q.push_back(d);
   endtask

   // one clock: check at negedge, drive, advance model at posedge, back to negedge
   task automatic cycle(input bit v, input logic [DW-1:0] d);
      check_outputs();
      i_data_valid = v;
      iv_data = d;
      @(posedge clk_ser);
      model_step(v, d);
      @(negedge clk_ser);
   endtask

   task automatic check_ready_rise();
      int lows;
      bit seen;
      lows = 0; seen = 1'b0;
      for (int i = 0; i < 60 && !seen; i++) begin
         if (o_data_ready) seen = 1'b1;
         else begin lows++; cycle(1'b0, '0); end
      end
      chk("ready_rise_cycle", 16'(lows), 16'd29);
   endtask

   initial begin
      logic [DW-1:0] pend;
      logic [6:0]    cap1;
      logic [6:0]    cap0;
      int            acc_cnt;
      bit            got;

      model_reset();
      #1 reset_ser = 1'b1;
      repeat (20) begin
         @(negedge clk_ser);
         chk("reset_lane", 16'(ov_lane), 16'd0);
         chk("reset_fco_ws_rdy", 16'({o_fco, o_word_start, o_data_ready}), 16'd0);
      end
      reset_ser = 1'b0;
      check_ready_rise();

      // single word 14'h1ABC
      cycle(1'b1, 14'h1ABC);
      got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
         if (o_word_start) got = 1'b1;
         else cycle(1'b0, '0);
      end
      chk("single_ws_seen", 16'(got), 16'd1);
      cap1 = '0; cap0 = '0;
      for (int i = 0; i < SR; i++) begin
         cap1 = {cap1[5:0], ov_lane[1]};
         cap0 = {cap0[5:0], ov_lane[0]};
         cycle(1'b0, '0);
      end
      chk("single_lane1", 16'(cap1), 16'b0110101);
      chk("single_lane0", 16'(cap0), 16'b0111100);
      repeat (10) cycle(1'b0, '0);

      // back-to-back stream with incrementing words
      pend = '0;
      acc_cnt = 0;
      for (int i = 0; i < 90; i++) begin
         if (i >= 20 && o_data_ready) acc_cnt++;
         got = model_ready();
         cycle(1'b1, pend);
         if (got) pend = pend + 14'd1;
      end
      chk("stream_accept_rate", 16'(acc_cnt), 16'd10);
      repeat (30) cycle(1'b0, '0);

      // randomized bursts; the source holds a word until it is taken
      pend = 14'($urandom);
      for (int i = 0; i < 400; i++) begin
         bit v;
         v = ($urandom_range(0, 3) != 0);
         got = v && model_ready();
         cycle(v, pend);
         if (got) pend = 14'($urandom);
      end

      // reset mid-word with a full buffer
      got = 1'b0;
      for (int i = 0; i < 60 && !got; i++) begin
         if (m_q.size() == 2 && m_cnt == 3) got = 1'b1;
         else cycle(1'b1, pend);
      end
      chk("midword_reach", 16'(got), 16'd1);
      reset_ser = 1'b1;
      #1;
      chk("midword_lane_async", 16'(ov_lane), 16'd0);
      chk("midword_fco_ws_rdy", 16'({o_fco, o_word_start, o_data_ready}), 16'd0);
      i_data_valid = 1'b0;
      repeat (5) @(negedge clk_ser);
      chk("midword_lane_hold", 16'(ov_lane), 16'd0);
      model_reset();
      reset_ser = 1'b0;
      check_ready_rise();
      repeat (20) cycle(1'b0, '0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
